// File: rtl/phase_sequencer.sv
// phase_sequencer
// -----------------------------------------------------------------------------
// Multi-cycle execution sequencer for the SIMPLE core. Produces a one-hot
// phase vector plus per-phase enable strobes so every architectural register
// runs on clk with an enable. Adds run/stop control from the exec button,
// drain to an instruction boundary, halt, memory-wait stall, and a
// retired-instruction counter.
//
// Optional feature macro: PHASE_SEQ_STEP_EN (adds the single-step input).
//
// Parameters:
//   NPHASE    - phases per instruction (3..8)
//   WAIT_MASK - bit i set: phase i may be stretched by mem_wait
//   CNT_W     - width of the retired-instruction counter
//
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  synchronous active-low reset
//   exec     in  run/stop button level (rising edges act)
//   step     in  single-step button level (PHASE_SEQ_STEP_EN only)
//   halt_req in  decoded HLT, sampled during the last phase's enabled cycle
//   mem_wait in  memory not ready; stalls masked phases
//   phase    out one-hot current phase
//   pen      out phase enable = phase gated by (running & ~stall)
//   running  out state is RUN or DRAIN
//   halted   out state is HALT
//   instret  out retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module phase_sequencer #(
    parameter int unsigned         NPHASE    = 5,
    parameter logic [NPHASE-1:0]   WAIT_MASK = NPHASE'(5'b00010),
    parameter int unsigned         CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              exec,
`ifdef PHASE_SEQ_STEP_EN
    input  logic              step,
`endif
    input  logic              halt_req,
    input  logic              mem_wait,
    output logic [NPHASE-1:0] phase,
    output logic [NPHASE-1:0] pen,
    output logic              running,
    output logic              halted,
    output logic [CNT_W-1:0]  instret
);

    if (NPHASE < 3 || NPHASE > 8) begin : g_bad_nphase
        $error("phase_sequencer: NPHASE must be in 3..8");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [NPHASE-1:0] PHASE0 = NPHASE'(1);

    state_t             state_q, state_d;
    logic [NPHASE-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               exec_q;
    logic               exec_rise;
    logic               run_w;
    logic               stall;
    logic               done;
    logic [NPHASE-1:0]  pen_w;

`ifdef PHASE_SEQ_STEP_EN
    logic               step_q;
    logic               step_rise;
    assign step_rise = step & ~step_q;
`endif

    assign exec_rise = exec & ~exec_q;
    assign run_w     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign stall     = run_w & mem_wait & (|(phase_q & WAIT_MASK));
    assign pen_w     = (run_w && !stall) ? phase_q : '0;
    // An instruction retires in the enabled cycle of its last phase.
    assign done      = pen_w[NPHASE-1];

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        instret_d = instret_q;

        unique case (state_q)
            S_IDLE: begin
                if (exec_rise) begin
                    state_d = S_RUN;
`ifdef PHASE_SEQ_STEP_EN
                end else if (step_rise) begin
                    state_d = S_DRAIN;
`endif
                end
            end
            S_RUN: begin
                if (done && halt_req) begin
                    state_d = S_HALT;
                end else if (exec_rise) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (done) begin
                    state_d = halt_req ? S_HALT : S_IDLE;
                end
            end
            S_HALT: begin
                if (exec_rise) begin
                    state_d = S_RUN;
`ifdef PHASE_SEQ_STEP_EN
                end else if (step_rise) begin
                    state_d = S_DRAIN;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Stopped states park on phase 0 so a restart begins a fresh fetch.
        if (state_d == S_IDLE || state_d == S_HALT) begin
            phase_d = PHASE0;
        end else if (|pen_w) begin
            phase_d = {phase_q[NPHASE-2:0], phase_q[NPHASE-1]};
        end

        if (done) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= PHASE0;
            instret_q <= '0;
            // Held high in reset so a button pressed through reset is not a rise.
            exec_q    <= 1'b1;
`ifdef PHASE_SEQ_STEP_EN
            step_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            instret_q <= instret_d;
            exec_q    <= exec;
`ifdef PHASE_SEQ_STEP_EN
            step_q    <= step;
`endif
        end
    end

    assign phase   = phase_q;
    assign pen     = pen_w;
    assign running = run_w;
    assign halted  = (state_q == S_HALT);
    assign instret = instret_q;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exec;
    logic        halt_req;
    logic        mem_wait;
`ifdef PHASE_SEQ_STEP_EN
    logic        step;
`endif

    logic [4:0]  phase,  phase4;
    logic [4:0]  pen,    pen4;
    logic        running, running4;
    logic        halted,  halted4;
    logic [15:0] instret;
    logic [3:0]  instret4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    phase_sequencer #(
        .NPHASE   (5),
        .WAIT_MASK(5'b00010),
        .CNT_W    (16)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .exec    (exec),
`ifdef PHASE_SEQ_STEP_EN
        .step    (step),
`endif
        .halt_req(halt_req),
        .mem_wait(mem_wait),
        .phase   (phase),
        .pen     (pen),
        .running (running),
        .halted  (halted),
        .instret (instret)
    );

    phase_sequencer #(
        .NPHASE   (5),
        .WAIT_MASK(5'b00010),
        .CNT_W    (4)
    ) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .exec    (exec),
`ifdef PHASE_SEQ_STEP_EN
        .step    (step),
`endif
        .halt_req(halt_req),
        .mem_wait(mem_wait),
        .phase   (phase4),
        .pen     (pen4),
        .running (running4),
        .halted  (halted4),
        .instret (instret4)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_exec();
        exec = 1'b1;
        tick();
        exec = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        total++; if (phase !== 5'b00001) begin bad++; $display("FAIL reset_phase got=%b exp=00001", phase); end
        total++; if (pen !== 5'b00000) begin bad++; $display("FAIL reset_pen got=%b exp=00000", pen); end
        total++; if (running !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", running, halted); end
        total++; if (instret !== 16'd0) begin bad++; $display("FAIL reset_instret got=%0d exp=0", instret); end
        tick();  // exec_q now follows exec=0
        total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b exp=0", running); end
    endtask

    task automatic test_run();
        logic [4:0] exp;
        pulse_exec();
        for (int i = 0; i < 20; i++) begin
            exp = 5'(1 << (i % 5));
            total++; if (pen !== exp) begin bad++; $display("FAIL run_pen cyc=%0d got=%b exp=%b", i, pen, exp); end
            if (i % 5 == 0) begin
                total++; if (instret !== 16'(i / 5)) begin bad++; $display("FAIL run_instret cyc=%0d got=%0d exp=%0d", i, instret, i / 5); end
            end
            tick();
        end
        total++; if (instret !== 16'd4) begin bad++; $display("FAIL run_instret20 got=%0d exp=4", instret); end
    endtask

    task automatic test_stall();
        total++; if (pen !== 5'b00001) begin bad++; $display("FAIL stall_start got=%b exp=00001", pen); end
        tick();
        mem_wait = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (phase !== 5'b00010 || pen !== 5'b00000) begin bad++; $display("FAIL stall_hold cyc=%0d got=%b/%b exp=00010/00000", i, phase, pen); end
            tick();
        end
        mem_wait = 1'b0;
        #1;
        total++; if (pen !== 5'b00010) begin bad++; $display("FAIL stall_release got=%b exp=00010", pen); end
        tick();
        mem_wait = 1'b1;
        #1;
        total++; if (pen !== 5'b00100) begin bad++; $display("FAIL stall_unmasked got=%b exp=00100", pen); end
        tick();
        mem_wait = 1'b0;
        total++; if (pen !== 5'b01000) begin bad++; $display("FAIL stall_p3 got=%b exp=01000", pen); end
        tick();
        total++; if (pen !== 5'b10000 || instret !== 16'd4) begin bad++; $display("FAIL stall_p4 got=%b/%0d exp=10000/4", pen, instret); end
        tick();
        total++; if (pen !== 5'b00001 || instret !== 16'd5) begin bad++; $display("FAIL stall_done got=%b/%0d exp=00001/5", pen, instret); end
    endtask

    task automatic test_halt();
        logic [4:0] exp;
        halt_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = 5'(1 << i);
            total++; if (pen !== exp || running !== 1'b1) begin bad++; $display("FAIL halt_ignored cyc=%0d got=%b/%b exp=%b/1", i, pen, running, exp); end
            tick();
        end
        total++; if (pen !== 5'b10000) begin bad++; $display("FAIL halt_last got=%b exp=10000", pen); end
        tick();
        halt_req = 1'b0;
        total++; if (halted !== 1'b1 || running !== 1'b0) begin bad++; $display("FAIL halt_state got=%b%b exp=10", halted, running); end
        total++; if (phase !== 5'b00001 || pen !== 5'b00000) begin bad++; $display("FAIL halt_phase got=%b/%b exp=00001/00000", phase, pen); end
        total++; if (instret !== 16'd6) begin bad++; $display("FAIL halt_instret got=%0d exp=6", instret); end
        tick();
        total++; if (halted !== 1'b1 || pen !== 5'b00000) begin bad++; $display("FAIL halt_stay got=%b/%b exp=1/00000", halted, pen); end
        pulse_exec();
        total++; if (pen !== 5'b00001 || halted !== 1'b0 || running !== 1'b1) begin bad++; $display("FAIL halt_resume got=%b/%b%b exp=00001/01", pen, halted, running); end
        total++; if (instret !== 16'd6) begin bad++; $display("FAIL halt_resume_instret got=%0d exp=6", instret); end
    endtask

    task automatic test_drain();
        tick();
        tick();
        total++; if (phase !== 5'b00100) begin bad++; $display("FAIL drain_pre got=%b exp=00100", phase); end
        pulse_exec();
        total++; if (pen !== 5'b01000 || running !== 1'b1) begin bad++; $display("FAIL drain_p3 got=%b/%b exp=01000/1", pen, running); end
        tick();
        total++; if (pen !== 5'b10000) begin bad++; $display("FAIL drain_p4 got=%b exp=10000", pen); end
        exec = 1'b1;  // second rise while draining has no effect
        tick();
        exec = 1'b0;
        total++; if (running !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL drain_idle got=%b%b exp=00", running, halted); end
        total++; if (phase !== 5'b00001 || pen !== 5'b00000) begin bad++; $display("FAIL drain_phase got=%b/%b exp=00001/00000", phase, pen); end
        total++; if (instret !== 16'd7) begin bad++; $display("FAIL drain_instret got=%0d exp=7", instret); end
        tick();
        total++; if (running !== 1'b0) begin bad++; $display("FAIL drain_stay got=%b exp=0", running); end
        // exec held through reset must not start execution
        rst_n = 1'b0;
        exec  = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        total++; if (running !== 1'b0 || pen !== 5'b00000) begin bad++; $display("FAIL held_exec got=%b/%b exp=0/00000", running, pen); end
        exec = 1'b0;
        tick();
        total++; if (running !== 1'b0 || instret !== 16'd0 || instret4 !== 4'd0) begin bad++; $display("FAIL held_release got=%b/%0d/%0d exp=0/0/0", running, instret, instret4); end
    endtask

    task automatic test_wrap();
        pulse_exec();
        for (int i = 0; i < 85; i++) tick();
        total++; if (instret4 !== 4'd1) begin bad++; $display("FAIL wrap_cnt4 got=%0d exp=1", instret4); end
        total++; if (instret !== 16'd17) begin bad++; $display("FAIL wrap_cnt16 got=%0d exp=17", instret); end
        total++; if (pen !== 5'b00001) begin bad++; $display("FAIL wrap_pen got=%b exp=00001", pen); end
        tick();
        tick();
        tick();
        total++; if (phase !== 5'b01000) begin bad++; $display("FAIL midrst_pre got=%b exp=01000", phase); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (phase !== 5'b00001 || pen !== 5'b00000) begin bad++; $display("FAIL midrst_phase got=%b/%b exp=00001/00000", phase, pen); end
        total++; if (running !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL midrst_state got=%b%b exp=00", running, halted); end
        total++; if (instret !== 16'd0 || instret4 !== 4'd0) begin bad++; $display("FAIL midrst_instret got=%0d/%0d exp=0/0", instret, instret4); end
        tick();
    endtask

`ifdef PHASE_SEQ_STEP_EN
    task automatic test_step();
        logic [4:0] exp;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp = 5'(1 << i);
            total++; if (pen !== exp) begin bad++; $display("FAIL step_pen cyc=%0d got=%b exp=%b", i, pen, exp); end
            tick();
        end
        total++; if (running !== 1'b0 || pen !== 5'b00000 || instret !== 16'd1) begin bad++; $display("FAIL step_idle got=%b/%b/%0d exp=0/00000/1", running, pen, instret); end
        tick();
        exec = 1'b1;
        step = 1'b1;
        tick();
        exec = 1'b0;
        step = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        total++; if (running !== 1'b1 || instret !== 16'd3) begin bad++; $display("FAIL step_exec_win got=%b/%0d exp=1/3", running, instret); end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        exec     = 1'b0;
        halt_req = 1'b0;
        mem_wait = 1'b0;
`ifdef PHASE_SEQ_STEP_EN
        step     = 1'b0;
`endif
        test_reset();
        test_run();
        test_stall();
        test_halt();
        test_drain();
        test_wrap();
`ifdef PHASE_SEQ_STEP_EN
        test_step();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
